// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the iterative divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int CYCLES = 32;
    localparam logic [DEF_WIDTH-1:0] DIV0_QUO = '1;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle between the EX stage and the divider.
interface div_unit_if #(parameter int WIDTH = 32);
    logic start;
    logic signed_div;
    logic annul;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic div_stall;
    logic ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    modport master (output start, signed_div, annul, a, b,
                    input div_stall, ready, quotient, remainder);
    modport slave (input start, signed_div, annul, a, b,
                   output div_stall, ready, quotient, remainder);
endinterface

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration (shift in a dividend bit, trial subtract).
module div_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    // rem < dvs always holds, so a non-negative difference fits in WIDTH bits
    always_comb begin
        shifted  = {rem, din};
        diff     = shifted - {1'b0, dvs};
        q_bit    = !diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider producing LO (quotient) and HI (remainder).
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CYCLES_P = CYCLES
) (
    input logic clk,
    input logic rst,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(CYCLES_P);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic neg_q_q, neg_q_d, neg_r_q, neg_r_d, ready_q, ready_d;
    logic [WIDTH-1:0] rem_next, q_full, abs_a, abs_b;
    logic q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem_q), .din(dvd_q[WIDTH-1]), .dvs(dvs_q),
        .rem_next(rem_next), .q_bit(q_bit)
    );

    always_comb begin
        q_full = {quo_q[WIDTH-2:0], q_bit};
        abs_a = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        state_d = state_q;
        cnt_d = cnt_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        quo_d = quo_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        quotient_d = quotient_q;
        remainder_d = remainder_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                dvd_d = abs_a;
                dvs_d = abs_b;
                rem_d = '0;
                quo_d = '0;
                neg_q_d = bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r_d = bus.signed_div && bus.a[WIDTH-1];
                state_d = (bus.b == '0) ? DONE : BUSY;
                cnt_d = CW'(CYCLES_P - 1);
                ready_d = (bus.b == '0);
                quotient_d = (bus.b == '0) ? DIV0_QUO : quotient_q;
                remainder_d = (bus.b == '0) ? bus.a : remainder_q;
            end
            BUSY: begin
                rem_d = rem_next;
                quo_d = q_full;
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    quotient_d = neg_q_q ? -q_full : q_full;
                    remainder_d = neg_r_q ? -rem_next : rem_next;
                end
            end
            default: state_d = IDLE;
        endcase
        // an abort leaves the architectural results untouched
        if (bus.annul) begin
            state_d = IDLE;
            ready_d = 1'b0;
            quotient_d = quotient_q;
            remainder_d = remainder_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            quotient_q <= '0;
            remainder_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            quotient_q <= quotient_d;
            remainder_q <= remainder_d;
            ready_q <= ready_d;
        end
    end

    assign bus.div_stall = (state_q == IDLE && bus.start && !bus.annul) || state_q == BUSY;
    assign bus.ready = ready_q;
    assign bus.quotient = quotient_q;
    assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with hand-computed results and timing.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int errors = 0;
    int first_rdy, second_rdy, pulses;

    div_unit_if #(.WIDTH(32)) bus();
    div_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // start on one cycle, garble operands afterwards, measure latency and stall length
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                           input int exp_lat);
        int lat = 40;
        int stalls = 0;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.signed_div = sgn;
        bus.start = 1'b1;
        #1 check({tag, " stall0"}, 32'(bus.div_stall), 32'd1);
        stalls = 1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'd3;
        bus.signed_div = ~sgn;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat = i;
                break;
            end
            if (bus.div_stall) stalls++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " stalls"}, 32'(stalls), 32'(exp_lat));
        check({tag, " done_stall"}, 32'(bus.div_stall), 32'd0);
        check({tag, " quo"}, bus.quotient, eq);
        check({tag, " rem"}, bus.remainder, er);
        @(negedge clk);
        check({tag, " ready_pulse"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.annul = 1'b0;
        bus.signed_div = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst ready", 32'(bus.ready), 32'd0);
        check("rst quo", bus.quotient, 32'd0);
        check("rst rem", bus.remainder, 32'd0);
        check("rst stall", 32'(bus.div_stall), 32'd0);

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
        run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("u-7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 33);
        run_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33);
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33);
        run_div("div0", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1);
        run_div("sdiv0", 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1);

        // annul during BUSY cycle 10 of 25/5
        @(negedge clk);
        bus.a = 32'd25;
        bus.b = 32'd5;
        bus.signed_div = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        check("annul stall", 32'(bus.div_stall), 32'd0);
        check("annul ready", 32'(bus.ready), 32'd0);
        check("annul quo", bus.quotient, 32'hFFFF_FFFF);
        check("annul rem", bus.remainder, 32'hFFFF_FF00);
        @(negedge clk);
        check("annul ready2", 32'(bus.ready), 32'd0);
        run_div("u25_5", 32'd25, 32'd5, 1'b0, 32'd5, 32'd0, 33);

        // start held through DONE and into the following IDLE cycle
        @(negedge clk);
        bus.a = 32'd100;
        bus.b = 32'd7;
        bus.start = 1'b1;
        pulses = 0;
        first_rdy = 0;
        second_rdy = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1 if (c == 35) bus.start = 1'b0;
            @(negedge clk);
            if (bus.ready) begin
                pulses++;
                if (pulses == 1) first_rdy = c;
                if (pulses == 2) second_rdy = c;
            end
        end
        check("b2b pulses", 32'(pulses), 32'd2);
        check("b2b first", 32'(first_rdy), 32'd33);
        check("b2b gap", 32'(second_rdy - first_rdy), 32'd34);
        check("b2b quo", bus.quotient, 32'd14);

        // synchronous reset mid-BUSY
        @(negedge clk);
        bus.a = 32'd1000;
        bus.b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst ready", 32'(bus.ready), 32'd0);
        check("mrst quo", bus.quotient, 32'd0);
        check("mrst rem", bus.remainder, 32'd0);
        check("mrst stall", 32'(bus.div_stall), 32'd0);
        repeat (30) @(negedge clk);
        check("mrst no_ready", 32'(bus.ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative 32-bit divider in the EX stage.
- Responds to the controller's divide request (isdivE / signeddivE) and drives the stall the pipeline uses to hold EX while the divide runs.
- Delivers quotient (LO) and remainder (HI) for the HI/LO write path.
- Radix-2 restoring algorithm: one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width in bits.
- CYCLES, 32, iteration count; must equal WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  divide request; isdivE qualified by valid EX instruction.
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- annul  in  1  abort in-flight divide (flushE / exception).
- a  in  WIDTH  dividend (rs).
- b  in  WIDTH  divisor (rt).
- div_stall  out  1  hold IF/ID/EX while asserted.
- ready  out  1  one-cycle pulse; result valid this cycle.
- quotient  out  WIDTH  to LO.
- remainder  out  WIDTH  to HI.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=0, quotient=0, remainder=0, counter=0, internal registers=0.
- States:
  - IDLE: on start && !annul, latch |a|, |b|, sign flags, and signed_div; clear partial remainder.
    - If b==0, go to DONE.
    - Otherwise go to BUSY with counter=CYCLES-1.
  - BUSY: each cycle, shift partial remainder left by 1 and bring in the next dividend MSB. Trial-subtract divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise keep the old value and set the bit to 0. Decrement counter. When counter==0, go to DONE.
  - DONE: ready=1 for exactly this cycle; quotient/remainder registers updated on entry; next state IDLE.
- div_stall = (state==IDLE && start && !annul) || state==BUSY. div_stall=0 in DONE, so EX advances at the end of the DONE cycle.
- Latency: the start cycle, plus 32 BUSY cycles, plus 1 DONE cycle. ready appears 33 cycles after the start-sampled cycle. The stall lasts 33 cycles.
- Signed correction, applied in the final BUSY cycle before DONE:
  - Quotient is negated iff signed_div and the operand signs differ.
  - Remainder takes the dividend's sign.
- Unsigned mode applies no correction.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives quotient=0x80000000, remainder=0. This wraps naturally and needs no special case.
- Divide by zero: quotient=0xFFFFFFFF, remainder=a (unmodified). ready is asserted in the cycle after start, and the stall lasts 1 cycle.
- quotient/remainder hold their last value between operations. They change only on entry to DONE.
- annul, any state: go to IDLE next cycle. No ready, outputs unchanged. annul wins over start in the same cycle.
- start in DONE is ignored; the same EX instruction is retiring. start seen back in IDLE next cycle begins a new divide.
- Operand changes on a/b/signed_div while BUSY are ignored; values are latched at start.
- rst mid-operation aborts immediately; all outputs take reset values next edge.

Decomposition:
- Shared package (div_pkg): state encoding (IDLE/BUSY/DONE, 2 bits), CYCLES constant, divide-by-zero quotient constant.
- One combinational sub-module div_step: inputs partial remainder, next dividend bit, and divisor. Outputs new partial remainder and quotient bit. It is instantiated once per cycle inside the FSM.

Test Plan:
- Unsigned 100/7 (start 1 cycle, signed_div=0) -> div_stall high 33 cycles; ready pulse at cycle 33; quotient=14, remainder=2.
- Signed -7/2 (a=0xFFFFFFF9, b=2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; ready at cycle 33.
- Divide by zero a=0x1234, b=0 -> ready in cycle after start, div_stall for 1 cycle only, quotient=0xFFFFFFFF, remainder=0x1234.
- annul asserted at BUSY cycle 10 of 25/5 -> state IDLE next cycle, no ready; quotient/remainder keep prior values. A new start 2 cycles later completes normally.
- Back-to-back: start held through DONE, then deasserted; a second start next cycle -> exactly two ready pulses 34 cycles apart. rst asserted mid-BUSY -> ready=0, quotient=remainder=0 after next edge.
